// File: rtl/cdcm8_rx_aligner.sv
// -----------------------------------------------------------------------------
// cdcm8_rx_aligner
//
// Receive-side symbol aligner for the CDCM-8 link. Each cycle it takes one
// 8-bit word from the deserializer. It looks for the symbol boundary by
// stepping a 0..7 bit offset until the idle waveform (kIdlePattern) is seen on
// kNumCheck consecutive aligned words. Once locked, each aligned word is
// decoded into a data bit, an idle marker or a symbol error. kMaxErr
// consecutive symbol errors drop lock, and the scan resumes at the next offset.
//
// Optional build macro: CDCM8_RX_ERRCNT_EN
//   When defined, adds errTotal. This is a saturating count of symbol-error
//   cycles while locked. Only reset clears it.
//
// Ports:
//   clkIn          word clock (divided clock), rising edge
//   ioResetN       synchronous active-low reset
//   dInFromSerdes  deserialized word, one per cycle
//   bitOut         decoded data bit (holds while bitValid=0)
//   bitValid       one-cycle strobe qualifying bitOut
//   idleOut        aligned word is the idle pattern (locked only)
//   symbolError    aligned word matches no pattern (locked only)
//   slipPos        bit offset under test, or the locked offset
//   aligned        high while locked
//   scanFinished   high once lock is achieved; cleared by reset or lock loss
//   errTotal       (CDCM8_RX_ERRCNT_EN only) saturating symbol-error count
//   fsmState       debug view of the FSM: 0 = SCAN, 1 = LOCKED
//
// Interface semantics: there is no back-pressure. One word is accepted every
// cycle. bitValid is a single-cycle qualifier for bitOut. Decode outputs
// appear two cycles after the word is sampled.
// -----------------------------------------------------------------------------
module cdcm8_rx_aligner #(
  parameter int          kDevW        = 8,
  parameter logic [7:0]  kIdlePattern = 8'hF0,
  parameter logic [7:0]  kPatternOne  = 8'hF8,
  parameter logic [7:0]  kPatternZero = 8'hE0,
  parameter int          kNumCheck    = 16,
  parameter int          kMaxErr      = 4
) (
  input  logic             clkIn,
  input  logic             ioResetN,
  input  logic [kDevW-1:0] dInFromSerdes,
  output logic             bitOut,
  output logic             bitValid,
  output logic             idleOut,
  output logic             symbolError,
  output logic [2:0]       slipPos,
  output logic             aligned,
  output logic             scanFinished,
`ifdef CDCM8_RX_ERRCNT_EN
  output logic [15:0]      errTotal,
`endif
  output logic             fsmState
);

  typedef enum logic {SCAN = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [7:0] kLockCnt  = 8'(kNumCheck - 1);
  localparam logic [7:0] kErrLimit = 8'(kMaxErr);

  state_t             state, stateN;
  logic [kDevW-1:0]   prevWord;
  logic [kDevW-1:0]   alignedWord;
  logic [2*kDevW-1:0] window;
  logic [kDevW-1:0]   alignedNext;
  logic [7:0]         matchCnt, matchCntN;
  logic [7:0]         errCnt, errCntN;
  logic [1:0]         blankCnt, blankCntN;
  logic [2:0]         slipPosN;
  logic               bitOutN, bitValidN, idleOutN, symbolErrorN;
  logic               alignedN, scanFinishedN;
`ifdef CDCM8_RX_ERRCNT_EN
  logic [15:0]        errTotalN;
`endif

  // The newest word sits on top, so a larger offset pulls in more of it.
  assign window      = {dInFromSerdes, prevWord};
  assign alignedNext = window[slipPos +: kDevW];
  assign fsmState    = state;

  always_ff @(posedge clkIn) begin
    if (!ioResetN) begin
      state        <= SCAN;
      prevWord     <= '0;
      alignedWord  <= '0;
      slipPos      <= 3'd0;
      matchCnt     <= 8'd0;
      errCnt       <= 8'd0;
      // alignedWord only holds real data two cycles after reset, so judging
      // it earlier would cause a spurious slip.
      blankCnt     <= 2'd2;
      bitOut       <= 1'b0;
      bitValid     <= 1'b0;
      idleOut      <= 1'b0;
      symbolError  <= 1'b0;
      aligned      <= 1'b0;
      scanFinished <= 1'b0;
`ifdef CDCM8_RX_ERRCNT_EN
      errTotal     <= 16'd0;
`endif
    end else begin
      state        <= stateN;
      prevWord     <= dInFromSerdes;
      alignedWord  <= alignedNext;
      slipPos      <= slipPosN;
      matchCnt     <= matchCntN;
      errCnt       <= errCntN;
      blankCnt     <= blankCntN;
      bitOut       <= bitOutN;
      bitValid     <= bitValidN;
      idleOut      <= idleOutN;
      symbolError  <= symbolErrorN;
      aligned      <= alignedN;
      scanFinished <= scanFinishedN;
`ifdef CDCM8_RX_ERRCNT_EN
      errTotal     <= errTotalN;
`endif
    end
  end

  always_comb begin
    stateN        = state;
    slipPosN      = slipPos;
    matchCntN     = matchCnt;
    errCntN       = errCnt;
    blankCntN     = blankCnt;
    bitOutN       = bitOut;
    bitValidN     = 1'b0;
    idleOutN      = 1'b0;
    symbolErrorN  = 1'b0;
    alignedN      = aligned;
    scanFinishedN = scanFinished;
`ifdef CDCM8_RX_ERRCNT_EN
    errTotalN     = errTotal;
`endif

    case (state)
      SCAN: begin
        if (blankCnt != 2'd0) begin
          // Window still refilling after a slip or reset.
          blankCntN = blankCnt - 2'd1;
        end else if (alignedWord == kIdlePattern) begin
          if (matchCnt == kLockCnt) begin
            stateN        = LOCKED;
            alignedN      = 1'b1;
            scanFinishedN = 1'b1;
            errCntN       = 8'd0;
            matchCntN     = 8'd0;
          end else begin
            matchCntN = matchCnt + 8'd1;
          end
        end else begin
          matchCntN = 8'd0;
          slipPosN  = slipPos + 3'd1;
          blankCntN = 2'd2;
        end
      end

      LOCKED: begin
        if (errCnt == kErrLimit) begin
          // The error run has ended lock. Resume the scan at the next offset.
          stateN        = SCAN;
          slipPosN      = slipPos + 3'd1;
          matchCntN     = 8'd0;
          errCntN       = 8'd0;
          blankCntN     = 2'd2;
          alignedN      = 1'b0;
          scanFinishedN = 1'b0;
          bitOutN       = 1'b0;
        end else if (alignedWord == kPatternOne) begin
          bitOutN   = 1'b1;
          bitValidN = 1'b1;
          errCntN   = 8'd0;
        end else if (alignedWord == kPatternZero) begin
          bitOutN   = 1'b0;
          bitValidN = 1'b1;
          errCntN   = 8'd0;
        end else if (alignedWord == kIdlePattern) begin
          idleOutN = 1'b1;
          errCntN  = 8'd0;
        end else begin
          symbolErrorN = 1'b1;
          if (errCnt != 8'hFF) errCntN = errCnt + 8'd1;
`ifdef CDCM8_RX_ERRCNT_EN
          if (errTotal != 16'hFFFF) errTotalN = errTotal + 16'd1;
`endif
        end
      end

      default: stateN = SCAN;
    endcase
  end

endmodule

// File: tb/tb_cdcm8_rx_aligner.sv
module tb_cdcm8_rx_aligner;

  logic       clkIn = 1'b0;
  logic       ioResetN = 1'b0;
  logic [7:0] dInFromSerdes = 8'hF0;
  logic       bitOut, bitValid, idleOut, symbolError, aligned, scanFinished;
  logic [2:0] slipPos;
  logic       fsmState;
`ifdef CDCM8_RX_ERRCNT_EN
  logic [15:0] errTotal;
`endif

  int vectors = 0;
  int miscompares = 0;

  cdcm8_rx_aligner dut (
    .clkIn         (clkIn),
    .ioResetN      (ioResetN),
    .dInFromSerdes (dInFromSerdes),
    .bitOut        (bitOut),
    .bitValid      (bitValid),
    .idleOut       (idleOut),
    .symbolError   (symbolError),
    .slipPos       (slipPos),
    .aligned       (aligned),
    .scanFinished  (scanFinished),
`ifdef CDCM8_RX_ERRCNT_EN
    .errTotal      (errTotal),
`endif
    .fsmState      (fsmState)
  );

  // clock / reset
  always #5 clkIn = ~clkIn;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one word, let it be sampled, then settle past the edge.
  task automatic step(input logic [7:0] w);
    dInFromSerdes = w;
    @(posedge clkIn);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] w);
    ioResetN = 1'b0;
    step(w);
    ioResetN = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bitOut"},   16'(bitOut), 16'd0);
    check({tag, "_bitValid"}, 16'(bitValid), 16'd0);
    check({tag, "_idle"},     16'(idleOut), 16'd0);
    check({tag, "_symErr"},   16'(symbolError), 16'd0);
    check({tag, "_slip"},     16'(slipPos), 16'd0);
    check({tag, "_aligned"},  16'(aligned), 16'd0);
    check({tag, "_scanFin"},  16'(scanFinished), 16'd0);
    check({tag, "_state"},    16'(fsmState), 16'd0);
  endtask

  // Count cycles until aligned rises, bounded. Reports each slip step.
  task automatic lock_run(input logic [7:0] w, output int cycles);
    logic [2:0] lastSlip;
    lastSlip = slipPos;
    cycles = 0;
    while (!aligned && cycles < 200) begin
      step(w);
      cycles++;
      if (slipPos != lastSlip) begin
        check("slip_step", 16'(slipPos), 16'(lastSlip + 3'd1));
        lastSlip = slipPos;
      end
    end
  endtask

  initial begin
    int cycles;
    logic [7:0] holdWords [9];
    logic       holdErr   [7];
    holdWords = '{8'h55, 8'h55, 8'hF8, 8'h55, 8'h55, 8'h55, 8'hF0, 8'hF0, 8'hF0};
    holdErr   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // 1: reset state and lock on a continuous idle stream at offset 0
    do_reset(8'hF0);
    check_all_zero("reset");
`ifdef CDCM8_RX_ERRCNT_EN
    check("reset_errTotal", errTotal, 16'd0);
`endif
    lock_run(8'hF0, cycles);
    check("lock0_cycles", 16'(cycles), 16'd18);
    check("lock0_slip", 16'(slipPos), 16'd0);
    check("lock0_scanFin", 16'(scanFinished), 16'd1);
    check("lock0_state", 16'(fsmState), 16'd1);

    // 2: decode F8, E0, F0, F8 with two-cycle latency
    step(8'hF8);
    step(8'hE0);
    step(8'hF0);
    check("dec0_valid", 16'(bitValid), 16'd1);
    check("dec0_bit", 16'(bitOut), 16'd1);
    check("dec0_idle", 16'(idleOut), 16'd0);
    step(8'hF8);
    check("dec1_valid", 16'(bitValid), 16'd1);
    check("dec1_bit", 16'(bitOut), 16'd0);
    step(8'hF0);
    check("dec2_valid", 16'(bitValid), 16'd0);
    check("dec2_idle", 16'(idleOut), 16'd1);
    check("dec2_bithold", 16'(bitOut), 16'd0);
    step(8'hF0);
    check("dec3_valid", 16'(bitValid), 16'd1);
    check("dec3_bit", 16'(bitOut), 16'd1);
    step(8'hF0);
    check("dec4_bithold", 16'(bitOut), 16'd1);
    check("dec4_valid", 16'(bitValid), 16'd0);

    // 3: four consecutive symbol errors drop lock and slip to offset 1
    step(8'hF0);
    step(8'h55);
    step(8'h55);
    step(8'h55);
    check("err0_sym", 16'(symbolError), 16'd1);
    step(8'h55);
    check("err1_sym", 16'(symbolError), 16'd1);
    step(8'hF0);
    check("err2_sym", 16'(symbolError), 16'd1);
    step(8'hF0);
    check("err3_sym", 16'(symbolError), 16'd1);
    check("err3_aligned", 16'(aligned), 16'd1);
    step(8'hF0);
    check("loss_aligned", 16'(aligned), 16'd0);
    check("loss_scanFin", 16'(scanFinished), 16'd0);
    check("loss_slip", 16'(slipPos), 16'd1);
    check("loss_sym", 16'(symbolError), 16'd0);
    check("loss_bitOut", 16'(bitOut), 16'd0);
    check("loss_state", 16'(fsmState), 16'd0);
`ifdef CDCM8_RX_ERRCNT_EN
    check("loss_errTotal", errTotal, 16'd4);
`endif

    // 4: rotated idle (0x87) locks at offset 3 after stepping 1,2,3
    do_reset(8'h87);
    check("reset2_slip", 16'(slipPos), 16'd0);
    lock_run(8'h87, cycles);
    check("lock3_cycles", 16'(cycles), 16'd27);
    check("lock3_slip", 16'(slipPos), 16'd3);
    check("lock3_scanFin", 16'(scanFinished), 16'd1);
    step(8'h87);
    step(8'h87);
    check("lock3_idle", 16'(idleOut), 16'd1);
    check("lock3_slipfrozen", 16'(slipPos), 16'd3);

    // 5: one-cycle reset mid-lock, then relock on idle at offset 0
    do_reset(8'h87);
    check_all_zero("midreset");
    lock_run(8'hF0, cycles);
    check("relock_cycles", 16'(cycles), 16'd18);
    check("relock_slip", 16'(slipPos), 16'd0);
    check("relock_aligned", 16'(aligned), 16'd1);

    // 6: interrupted error run keeps lock
    for (int i = 0; i < 9; i++) begin
      step(holdWords[i]);
      if (i >= 2) begin
        check($sformatf("hold%0d_sym", i - 2), 16'(symbolError), 16'(holdErr[i - 2]));
        check($sformatf("hold%0d_aligned", i - 2), 16'(aligned), 16'd1);
        check($sformatf("hold%0d_valid", i - 2), 16'(bitValid), 16'(i == 4));
      end
    end
    check("hold_slip", 16'(slipPos), 16'd0);
`ifdef CDCM8_RX_ERRCNT_EN
    check("hold_errTotal", errTotal, 16'd5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cdcm8_rx_aligner.md
Name: cdcm8_rx_aligner

Overview:
Receive-side counterpart of the CDCM-8 transmitter. Takes 8-bit parallel words from the input deserializer and finds the symbol boundary by sweeping a 0..7 bit offset against the idle waveform 0xF0, which the transmitter sends while in reset. Once locked, it decodes each aligned word into a data bit, an idle marker or a symbol error. Sits between the ISERDES word output and the link-layer bit/frame logic, in the divided-clock domain.

Parameters:
kDevW, 8, deserialized word width; only 8 is supported.
kIdlePattern, 8'hF0, aligned idle waveform.
kPatternOne, 8'hF8, aligned waveform for data bit 1.
kPatternZero, 8'hE0, aligned waveform for data bit 0.
kNumCheck, 16, consecutive idle matches needed to lock (range 2..255).
kMaxErr, 4, consecutive symbol errors that drop lock (range 1..255).

Ports:
clkIn  input  1  word clock (divided clock); all logic on rising edge.
ioResetN  input  1  synchronous, active-low reset.
dInFromSerdes  input  kDevW  deserialized word, one per cycle.
bitOut  output  1  decoded data bit.
bitValid  output  1  one-cycle strobe; bitOut is valid.
idleOut  output  1  aligned word equals kIdlePattern (LOCKED only).
symbolError  output  1  aligned word matches no pattern (LOCKED only).
slipPos  output  3  current bit offset under test or locked.
aligned  output  1  high in LOCKED.
scanFinished  output  1  high once lock has been achieved; cleared by reset or loss of lock.

Behaviour:
- Reset (ioResetN=0 at clock edge): prev=0, slipPos=0, matchCnt=0, errCnt=0, state=SCAN. All outputs 0.
- Window: w = {cur, prev} (16 bits), where prev is the previous input word. Aligned word a = w[slipPos +: 8]. a is registered, giving 1-cycle latency.
- Decode outputs are registered from a, so outputs appear 2 cycles after the input word.
- SCAN state:
  - a==kIdlePattern: matchCnt++. When matchCnt reaches kNumCheck-1 and this cycle also matches, go to LOCKED, set aligned=1 and scanFinished=1, clear errCnt.
  - Any mismatch: matchCnt=0, slipPos=(slipPos+1) mod 8 (7 wraps to 0). The two cycles after a slip change are blanked: no match and no slip, so the window refills.
  - bitValid, idleOut and symbolError are 0 in SCAN.
- LOCKED state, per aligned word:
  - kPatternOne: bitOut=1, bitValid=1, errCnt=0.
  - kPatternZero: bitOut=0, bitValid=1, errCnt=0.
  - kIdlePattern: idleOut=1, bitValid=0, errCnt=0.
  - Anything else: symbolError=1, errCnt++ (saturating).
  - When errCnt reaches kMaxErr: go to SCAN with slipPos+1 (mod 8), matchCnt=0, aligned=0, scanFinished=0, all decode outputs 0 on the next cycle.
  - slipPos is frozen while LOCKED.
- Simultaneous events: ioResetN has priority over every transition.
- bitOut holds its last value when bitValid=0.

Optional Feature:
CDCM8_RX_ERRCNT_EN
- Defined: adds output errTotal (16 bits). It counts every symbolError cycle in LOCKED and saturates at 16'hFFFF. Cleared only by reset; a lock loss does not clear it.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Continuous 0xF0 words after reset release -> slipPos stays 0; aligned=1 after exactly 16 matching aligned words; scanFinished=1.
- Continuous 0x87 words (0xF0 rotated by 3) -> slipPos steps 0,1,2,3 (with blanking) and locks at slipPos=3; aligned rises 16 matches later.
- After lock at slip 0, send 0xF8, 0xE0, 0xF0, 0xF8 -> bitValid pattern 1,1,0,1; bitOut 1,0,-,1; idleOut high on the third word; outputs 2 cycles after input.
- After lock, send four consecutive 0x55 words -> symbolError high for 4 cycles, then aligned=0, scanFinished=0, slipPos=1. With CDCM8_RX_ERRCNT_EN, errTotal=4.
- After lock, send 0x55, 0x55, 0xF8, 0x55, 0x55, 0x55 -> the counter resets on 0xF8, so lock is held with kMaxErr=4.
- Drive ioResetN low for one cycle mid-LOCKED -> next cycle all outputs 0, slipPos=0, state SCAN; relock follows with 0xF0 input.
